// File: rtl/rtx_dispatch_if.sv
// Lane request/result and pixel output bundle for rtx_dispatch.
// master = dispatcher side, slave = tracer lanes plus pixel sink.
interface rtx_dispatch_if #(
    parameter int NUM_LANES = 4,
    parameter int FP_W      = 24
);
    logic [NUM_LANES-1:0]        lane_req_valid;
    logic [NUM_LANES-1:0]        lane_req_ready;
    logic [10:0]                 lane_req_h;
    logic [9:0]                  lane_req_v;
    logic [NUM_LANES-1:0]        lane_res_valid;
    logic [NUM_LANES-1:0]        lane_res_ready;
    logic [NUM_LANES*11-1:0]     lane_res_h;
    logic [NUM_LANES*10-1:0]     lane_res_v;
    logic [NUM_LANES*3*FP_W-1:0] lane_res_color;
    logic                        out_valid;
    logic                        out_ready;
    logic [23:0]                 out_pixel;
    logic [10:0]                 out_h;
    logic [9:0]                  out_v;

    modport master (
        output lane_req_valid, lane_req_h, lane_req_v, lane_res_ready,
               out_valid, out_pixel, out_h, out_v,
        input  lane_req_ready, lane_res_valid, lane_res_h, lane_res_v,
               lane_res_color, out_ready
    );

    modport slave (
        input  lane_req_valid, lane_req_h, lane_req_v, lane_res_ready,
               out_valid, out_pixel, out_h, out_v,
        output lane_req_ready, lane_res_valid, lane_res_h, lane_res_v,
               lane_res_color, out_ready
    );
endinterface

// File: rtl/rtx_dispatch.sv
// Raster-order pixel dispatcher over NUM_LANES tracer lanes with a single pixel output register.
// Optional macro RTX_DISPATCH_CLIP_EN saturates out-of-range colour components instead of wrapping.
module rtx_dispatch #(
    parameter int WIDTH     = 1280,
    parameter int HEIGHT    = 720,
    parameter int NUM_LANES = 4,
    parameter int FP_W      = 24,
    parameter int FP_FRAC   = 16,
    parameter int PIXEL_FMT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           frame_done,
    rtx_dispatch_if.master bus
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = $clog2(WIDTH * HEIGHT + 1);
    localparam int KR = (PIXEL_FMT == 0) ? 5 : 8;
    localparam int KG = (PIXEL_FMT == 0) ? 6 : 8;
    localparam int KB = (PIXEL_FMT == 0) ? 5 : 8;
    localparam logic [10:0] H_LAST = 11'(WIDTH - 1);
    localparam logic [9:0]  V_LAST = 10'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   req_ptr_q, req_ptr_d;
    logic [LW-1:0]   res_ptr_q, res_ptr_d;
    logic [10:0]     h_q, h_d;
    logic [9:0]      v_q, v_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [23:0]     out_pixel_q, out_pixel_d;
    logic [10:0]     out_h_q, out_h_d;
    logic [9:0]      out_v_q, out_v_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q;

    logic                 req_found_s, res_found_s;
    logic [LW-1:0]        req_sel_s, res_sel_s;
    logic                 req_fire_s, res_take_s, out_fire_s;
    logic [NUM_LANES-1:0] req_valid_s, res_ready_s;
    logic [3*FP_W-1:0]    sel_color_s;

    // Fixed-point component to a k-bit unsigned code taken just below the binary point.
    function automatic logic [7:0] conv_comp(input logic [FP_W-1:0] c, input int k);
        logic [7:0] mask;
        logic [7:0] code;
        mask = 8'hFF >> (8 - k);
        code = 8'(c >> (FP_FRAC - k));
`ifdef RTX_DISPATCH_CLIP_EN
        if (c[FP_W-1]) begin
            return 8'h00;
        end else if (|c[FP_W-2:FP_FRAC]) begin
            return mask;
        end else begin
            return code & mask;
        end
`else
        return code & mask;
`endif
    endfunction

    function automatic logic [23:0] pack_pixel(input logic [3*FP_W-1:0] c);
        logic [7:0] r, g, b;
        r = conv_comp(c[FP_W-1:0], KR);
        g = conv_comp(c[2*FP_W-1:FP_W], KG);
        b = conv_comp(c[3*FP_W-1:2*FP_W], KB);
        if (PIXEL_FMT == 0) begin
            return {8'h00, b[4:0], g[5:0], r[4:0]};
        end else begin
            return {b, g, r};
        end
    endfunction

    // Round-robin pick of the first ready request lane and first valid result lane.
    always_comb begin
        req_found_s = 1'b0;
        req_sel_s   = '0;
        res_found_s = 1'b0;
        res_sel_s   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            req_sel_s   = (!req_found_s && bus.lane_req_ready[(int'(req_ptr_q) + i) % NUM_LANES])
                        ? LW'((int'(req_ptr_q) + i) % NUM_LANES) : req_sel_s;
            req_found_s = req_found_s | bus.lane_req_ready[(int'(req_ptr_q) + i) % NUM_LANES];
            res_sel_s   = (!res_found_s && bus.lane_res_valid[(int'(res_ptr_q) + i) % NUM_LANES])
                        ? LW'((int'(res_ptr_q) + i) % NUM_LANES) : res_sel_s;
            res_found_s = res_found_s | bus.lane_res_valid[(int'(res_ptr_q) + i) % NUM_LANES];
        end
    end

    // Handshake qualifiers; result acceptance is gated by reset so nothing is consumed while held.
    always_comb begin
        req_fire_s  = (state_q == S_DISPATCH) && req_found_s;
        out_fire_s  = out_valid_q && bus.out_ready;
        res_take_s  = rst_n && res_found_s && (!out_valid_q || bus.out_ready);
        req_valid_s = '0;
        res_ready_s = '0;
        req_valid_s[req_sel_s] = req_fire_s;
        res_ready_s[res_sel_s] = res_take_s;
        sel_color_s = bus.lane_res_color[int'(res_sel_s) * 3 * FP_W +: 3 * FP_W];
    end

    // Frame FSM, raster coordinates and request pointer.
    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        v_d          = v_q;
        req_ptr_d    = req_ptr_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // the cycle frame_done is visible still counts as the end of the previous frame
                if (start && !frame_done_q) begin
                    state_d = S_DISPATCH;
                    h_d     = 11'd0;
                    v_d     = 10'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DISPATCH: begin
                if (req_fire_s) begin
                    req_ptr_d = LW'((int'(req_sel_s) + 1) % NUM_LANES);
                    if ((h_q == H_LAST) && (v_q == V_LAST)) begin
                        state_d = S_DRAIN;
                        h_d     = 11'd0;
                        v_d     = 10'd0;
                    end else if (h_q == H_LAST) begin
                        h_d = 11'd0;
                        v_d = v_q + 10'd1;
                    end else begin
                        h_d = h_q + 11'd1;
                    end
                end else begin
                    state_d = S_DISPATCH;
                end
            end
            S_DRAIN: begin
                if ((cnt_q == '0) && !out_valid_q) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register, result pointer and outstanding count (floored at zero for post-reset leftovers).
    always_comb begin
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_h_d     = out_h_q;
        out_v_d     = out_v_q;
        res_ptr_d   = res_ptr_q;
        if (res_take_s) begin
            out_valid_d = 1'b1;
            out_pixel_d = pack_pixel(sel_color_s);
            out_h_d     = bus.lane_res_h[int'(res_sel_s) * 11 +: 11];
            out_v_d     = bus.lane_res_v[int'(res_sel_s) * 10 +: 10];
            res_ptr_d   = LW'((int'(res_sel_s) + 1) % NUM_LANES);
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        case ({req_fire_s, out_fire_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_ptr_q    <= '0;
            res_ptr_q    <= '0;
            h_q          <= 11'd0;
            v_q          <= 10'd0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_pixel_q  <= 24'd0;
            out_h_q      <= 11'd0;
            out_v_q      <= 10'd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ptr_q    <= req_ptr_d;
            res_ptr_q    <= res_ptr_d;
            h_q          <= h_d;
            v_q          <= v_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
            out_h_q      <= out_h_d;
            out_v_q      <= out_v_d;
            frame_done_q <= frame_done_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign busy               = busy_q;
    assign frame_done         = frame_done_q;
    assign bus.lane_req_valid = req_valid_s;
    assign bus.lane_req_h     = h_q;
    assign bus.lane_req_v     = v_q;
    assign bus.lane_res_ready = res_ready_s;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pixel      = out_pixel_q;
    assign bus.out_h          = out_h_q;
    assign bus.out_v          = out_v_q;
endmodule

// File: tb/tb_rtx_dispatch.sv
// Directed bench for rtx_dispatch on a 4x2 frame with two fixed-latency lane models.
module tb_rtx_dispatch;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int NL  = 2;
    localparam int FPW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, frame_done;

    rtx_dispatch_if #(.NUM_LANES(NL), .FP_W(FPW)) bus ();

    rtx_dispatch #(.WIDTH(W), .HEIGHT(H), .NUM_LANES(NL), .FP_W(FPW), .FP_FRAC(16), .PIXEL_FMT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {int h; int v; int t; logic [23:0] r; logic [23:0] g; logic [23:0] b;} ent_t;
    typedef struct {int lane; int h; int v;} req_t;
    typedef struct {int h; int v; logic [23:0] pix;} out_t;

    ent_t q0[$];
    ent_t q1[$];
    req_t req_log[$];
    out_t out_log[$];
    logic [1:0] gnt_log[$];

    int cyc, errors, checks, fd_cnt;
    logic [1:0] rdy;
    logic orr, timed_out;
    logic s_ov, s_busy;
    logic [23:0] s_pix;
    logic [10:0] s_h;
    logic [9:0] s_v;
    logic [1:0] s_rr;

    function automatic ent_t mk_col(input int h, input int v, input int t,
                                    input logic [23:0] r, input logic [23:0] g, input logic [23:0] b);
        ent_t e;
        e.h = h; e.v = v; e.t = t; e.r = r; e.g = g; e.b = b;
        return e;
    endfunction

    // Frame colours carry the coordinates: r5 = h, g6 = v, b = 0.
    function automatic ent_t mk_ent(input int h, input int v, input int t);
        return mk_col(h, v, t, 24'(h) << 11, 24'(v) << 10, 24'h0);
    endfunction

    task automatic drive_lanes();
        logic [10:0] h0, h1;
        logic [9:0] v0, v1;
        logic [71:0] c0, c1;
        logic vd0, vd1;
        vd0 = 1'b0; h0 = 11'd0; v0 = 10'd0; c0 = 72'd0;
        vd1 = 1'b0; h1 = 11'd0; v1 = 10'd0; c1 = 72'd0;
        if (q0.size() > 0) begin
            vd0 = (q0[0].t <= cyc); h0 = 11'(q0[0].h); v0 = 10'(q0[0].v); c0 = {q0[0].b, q0[0].g, q0[0].r};
        end
        if (q1.size() > 0) begin
            vd1 = (q1[0].t <= cyc); h1 = 11'(q1[0].h); v1 = 10'(q1[0].v); c1 = {q1[0].b, q1[0].g, q1[0].r};
        end
        bus.lane_res_valid = {vd1, vd0};
        bus.lane_res_h     = {h1, h0};
        bus.lane_res_v     = {v1, v0};
        bus.lane_res_color = {c1, c0};
        bus.lane_req_ready = rdy;
        bus.out_ready      = orr;
    endtask

    // One clock: sample mid-cycle, log handshakes, advance the lane models after the edge.
    task automatic step();
        logic [1:0] rq, rs;
        req_t rr;
        drive_lanes();
        #1;
        rq = bus.lane_req_valid & bus.lane_req_ready;
        rs = bus.lane_res_valid & bus.lane_res_ready;
        s_ov = bus.out_valid; s_pix = bus.out_pixel; s_h = bus.out_h; s_v = bus.out_v;
        s_rr = bus.lane_res_ready; s_busy = busy;
        if (frame_done) fd_cnt++;
        if (bus.out_valid && bus.out_ready) out_log.push_back('{int'(bus.out_h), int'(bus.out_v), bus.out_pixel});
        if (rs != 2'b00) gnt_log.push_back(rs);
        rr = '{-1, 0, 0};
        if (rq != 2'b00) begin
            rr.lane = (rq == 2'b01) ? 0 : ((rq == 2'b10) ? 1 : -1);
            rr.h = int'(bus.lane_req_h);
            rr.v = int'(bus.lane_req_v);
            req_log.push_back(rr);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rs[0] && q0.size() > 0) void'(q0.pop_front());
        if (rs[1] && q1.size() > 0) void'(q1.pop_front());
        if (rq[0]) q0.push_back(mk_ent(rr.h, rr.v, cyc + 2));
        if (rq[1]) q1.push_back(mk_ent(rr.h, rr.v, cyc + 2));
        drive_lanes();
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); req_log.delete(); out_log.delete(); gnt_log.delete();
        fd_cnt = 0;
    endtask

    task automatic run_frame(input int budget);
        timed_out = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (fd_cnt > 0) break;
        end
        if (fd_cnt == 0) timed_out = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rdy = 2'b00; orr = 1'b0;
        drive_lanes();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got busy=%0b done=%0b required 0 0", busy, frame_done); end
        checks++; if (bus.out_valid !== 1'b0 || bus.lane_req_valid !== 2'b00 || bus.lane_res_ready !== 2'b00) begin errors++; $display("FAIL reset_valids: got ov=%0b rqv=%0b rsr=%0b required 0", bus.out_valid, bus.lane_req_valid, bus.lane_res_ready); end
        checks++; if ({bus.out_pixel, bus.out_h, bus.out_v} !== 45'd0) begin errors++; $display("FAIL reset_out: got pix=%0h h=%0d v=%0d required 0", bus.out_pixel, bus.out_h, bus.out_v); end
        checks++; if ({bus.lane_req_h, bus.lane_req_v} !== 21'd0) begin errors++; $display("FAIL reset_coord: got h=%0d v=%0d required 0 0", bus.lane_req_h, bus.lane_req_v); end
        rst_n = 1'b1;
        repeat (2) step();
        checks++; if (s_busy !== 1'b0 || s_ov !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%0b ov=%0b required 0 0", s_busy, s_ov); end
    endtask

    task automatic test_frame();
        clear_model(); rdy = 2'b11; orr = 1'b1; timed_out = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            start = (i == 2);
            step();
            if (fd_cnt > 0) break;
        end
        start = 1'b0;
        repeat (3) step();
        checks++; if (req_log.size() != 8) begin errors++; $display("FAIL frame_req_count: got %0d required 8", req_log.size()); end
        for (int i = 0; i < req_log.size(); i++) begin
            checks++; if (req_log[i].lane != i % 2 || req_log[i].h != i % W || req_log[i].v != i / W) begin errors++; $display("FAIL frame_req_%0d: got lane=%0d (%0d,%0d) required lane=%0d (%0d,%0d)", i, req_log[i].lane, req_log[i].h, req_log[i].v, i % 2, i % W, i / W); end
        end
        checks++; if (out_log.size() != 8) begin errors++; $display("FAIL frame_out_count: got %0d required 8", out_log.size()); end
        for (int i = 0; i < out_log.size(); i++) begin
            checks++; if (out_log[i].h != i % W || out_log[i].v != i / W || out_log[i].pix !== 24'(((i / W) << 5) | (i % W))) begin errors++; $display("FAIL frame_out_%0d: got (%0d,%0d) %0h required (%0d,%0d) %0h", i, out_log[i].h, out_log[i].v, out_log[i].pix, i % W, i / W, 24'(((i / W) << 5) | (i % W))); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL frame_done_pulses: got %0d required 1", fd_cnt); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end: got %0b required 0", s_busy); end
    endtask

    task automatic test_backpressure();
        logic [23:0] rp;
        logic [10:0] rh;
        logic [9:0] rv;
        logic [7:0] seen;
        int bad, idx;
        clear_model(); rdy = 2'b11; orr = 1'b1; timed_out = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        orr = 1'b0;
        step();
        rp = s_pix; rh = s_h; rv = s_v;
        checks++; if (s_ov !== 1'b1 || s_rr !== 2'b00) begin errors++; $display("FAIL hold_enter: got ov=%0b rsr=%0b required 1 0", s_ov, s_rr); end
        for (int i = 0; i < 9; i++) begin
            step();
            checks++; if (s_ov !== 1'b1 || s_pix !== rp || s_h !== rh || s_v !== rv) begin errors++; $display("FAIL hold_stable_%0d: got ov=%0b %0h (%0d,%0d) required 1 %0h (%0d,%0d)", i, s_ov, s_pix, s_h, s_v, rp, rh, rv); end
            checks++; if (s_rr !== 2'b00) begin errors++; $display("FAIL hold_res_ready_%0d: got %0b required 0", i, s_rr); end
        end
        orr = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (fd_cnt > 0) break;
        end
        repeat (3) step();
        seen = 8'h00; bad = 0;
        for (int i = 0; i < out_log.size(); i++) begin
            idx = out_log[i].v * W + out_log[i].h;
            if (idx >= 0 && idx < 8 && out_log[i].pix === 24'((out_log[i].v << 5) | out_log[i].h)) seen[idx] = 1'b1;
            else bad++;
        end
        checks++; if (out_log.size() != 8 || seen !== 8'hFF || bad != 0) begin errors++; $display("FAIL bp_outputs: got n=%0d seen=%0h bad=%0d required 8 ff 0", out_log.size(), seen, bad); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL bp_frame_done: got %0d required 1", fd_cnt); end
    endtask

    task automatic test_reset_midframe();
        clear_model(); rdy = 2'b11; orr = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, frame_done, bus.out_valid, bus.lane_req_valid, bus.lane_res_ready} !== 7'd0) begin errors++; $display("FAIL midrst_ctrl: got %0b required 0", {busy, frame_done, bus.out_valid, bus.lane_req_valid, bus.lane_res_ready}); end
        checks++; if ({bus.out_pixel, bus.out_h, bus.out_v, bus.lane_req_h, bus.lane_req_v} !== 66'd0) begin errors++; $display("FAIL midrst_data: got pix=%0h (%0d,%0d) req (%0d,%0d) required 0", bus.out_pixel, bus.out_h, bus.out_v, bus.lane_req_h, bus.lane_req_v); end
        clear_model();
        drive_lanes();
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        rst_n = 1'b1;
        run_frame(100);
        checks++; if (timed_out !== 1'b0 || fd_cnt != 1) begin errors++; $display("FAIL midrst_frame_done: got pulses=%0d timeout=%0b required 1 0", fd_cnt, timed_out); end
        checks++; if (req_log.size() != 8 || out_log.size() != 8) begin errors++; $display("FAIL midrst_counts: got req=%0d out=%0d required 8 8", req_log.size(), out_log.size()); end
        for (int i = 0; i < req_log.size(); i++) begin
            checks++; if (req_log[i].lane != i % 2 || req_log[i].h != i % W || req_log[i].v != i / W) begin errors++; $display("FAIL midrst_req_%0d: got lane=%0d (%0d,%0d) required lane=%0d (%0d,%0d)", i, req_log[i].lane, req_log[i].h, req_log[i].v, i % 2, i % W, i / W); end
        end
    endtask

    task automatic test_grant();
        int eh[4] = '{1, 2, 3, 0};
        int ev[4] = '{0, 1, 0, 1};
        rst_n = 1'b0;
        clear_model(); rdy = 2'b00; orr = 1'b1;
        drive_lanes();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        q0.push_back(mk_ent(1, 0, cyc)); q0.push_back(mk_ent(3, 0, cyc));
        q1.push_back(mk_ent(2, 1, cyc)); q1.push_back(mk_ent(0, 1, cyc));
        repeat (6) step();
        checks++; if (gnt_log.size() != 4) begin errors++; $display("FAIL grant_count: got %0d required 4", gnt_log.size()); end
        for (int i = 0; i < gnt_log.size(); i++) begin
            checks++; if (gnt_log[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL grant_%0d: got %0b required %0b", i, gnt_log[i], (i % 2 == 0) ? 2'b01 : 2'b10); end
        end
        checks++; if (out_log.size() != 4) begin errors++; $display("FAIL grant_out_count: got %0d required 4", out_log.size()); end
        for (int i = 0; i < out_log.size() && i < 4; i++) begin
            checks++; if (out_log[i].h != eh[i] || out_log[i].v != ev[i] || out_log[i].pix !== 24'((ev[i] << 5) | eh[i])) begin errors++; $display("FAIL grant_out_%0d: got (%0d,%0d) %0h required (%0d,%0d) %0h", i, out_log[i].h, out_log[i].v, out_log[i].pix, eh[i], ev[i], 24'((ev[i] << 5) | eh[i])); end
        end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL grant_idle_busy: got %0b required 0", s_busy); end
    endtask

    task automatic test_fmt();
`ifdef RTX_DISPATCH_CLIP_EN
        logic [23:0] ep[4] = '{24'h008410, 24'h00841F, 24'h008400, 24'h0007E0};
`else
        logic [23:0] ep[4] = '{24'h008410, 24'h008410, 24'h008410, 24'h0007E0};
`endif
        clear_model(); rdy = 2'b00; orr = 1'b1;
        q0.push_back(mk_col(5, 6, cyc, 24'h008000, 24'h008000, 24'h008000));
        q0.push_back(mk_col(6, 6, cyc, 24'h018000, 24'h008000, 24'h008000));
        q0.push_back(mk_col(7, 6, cyc, 24'hFF8000, 24'h008000, 24'h008000));
        q0.push_back(mk_col(8, 6, cyc, 24'h000000, 24'h00FFFF, 24'h000000));
        repeat (6) step();
        checks++; if (out_log.size() != 4) begin errors++; $display("FAIL fmt_count: got %0d required 4", out_log.size()); end
        for (int i = 0; i < out_log.size() && i < 4; i++) begin
            checks++; if (out_log[i].pix !== ep[i] || out_log[i].h != 5 + i || out_log[i].v != 6) begin errors++; $display("FAIL fmt_pix_%0d: got %0h (%0d,%0d) required %0h (%0d,6)", i, out_log[i].pix, out_log[i].h, out_log[i].v, ep[i], 5 + i); end
        end
    endtask

    task automatic test_count_floor();
        clear_model(); rdy = 2'b11; orr = 1'b1;
        run_frame(100);
        checks++; if (timed_out !== 1'b0 || fd_cnt != 1) begin errors++; $display("FAIL floor_frame_done: got pulses=%0d timeout=%0b required 1 0", fd_cnt, timed_out); end
        checks++; if (out_log.size() != 8 || s_busy !== 1'b0) begin errors++; $display("FAIL floor_drain: got out=%0d busy=%0b required 8 0", out_log.size(), s_busy); end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; fd_cnt = 0;
        rdy = 2'b00; orr = 1'b0; timed_out = 1'b0;
        test_reset();
        test_frame();
        test_backpressure();
        test_reset_midframe();
        test_grant();
        test_fmt();
        test_count_floor();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rtx_dispatch.md
RTX_DISPATCH -- requirements
Module: rtx_dispatch

Interface
REQ-001 SHALL have parameters: WIDTH, 1280, frame columns; HEIGHT, 720, frame rows; NUM_LANES, 4, tracer lanes (1..8); FP_W, 24, colour component width, signed fixed point; FP_FRAC, 16, fractional bits; PIXEL_FMT, 0, 0=RGB565, 1=RGB888.
REQ-002 SHALL have ports: clk, in, 1, sole clock; rst_n, in, 1, asynchronous active-low reset.
REQ-003 SHALL have ports: start, in, 1, frame trigger pulse; busy, out, 1, frame in progress; frame_done, out, 1, one-cycle end-of-frame pulse.
REQ-004 SHALL have request ports: lane_req_valid, out, NUM_LANES, request to each lane; lane_req_ready, in, NUM_LANES, lane accepts; lane_req_h, out, 11, shared column; lane_req_v, out, 10, shared row.
REQ-005 SHALL have result ports: lane_res_valid, in, NUM_LANES, lane result present; lane_res_ready, out, NUM_LANES, result consumed; lane_res_h, in, NUM_LANES*11; lane_res_v, in, NUM_LANES*10; lane_res_color, in, NUM_LANES*3*FP_W, per lane {b,g,r}.
REQ-006 SHALL have output ports: out_valid, out, 1; out_ready, in, 1; out_pixel, out, 24; out_h, out, 11; out_v, out, 10.

Function
REQ-007 SHALL implement states IDLE, DISPATCH, DRAIN; IDLE->DISPATCH on start; DISPATCH->DRAIN when pixel (WIDTH-1,HEIGHT-1) is accepted; DRAIN->IDLE when outstanding count is 0 and out_valid is 0.
REQ-008 SHALL ignore start outside IDLE; busy SHALL be 1 in DISPATCH and DRAIN.
REQ-009 SHALL issue at most one request per cycle, asserting lane_req_valid on exactly one lane: the first lane with lane_req_ready=1 at or after the round-robin pointer, wrapping modulo NUM_LANES.
REQ-010 SHALL advance the request pointer to one past the accepted lane on each request handshake.
REQ-011 SHALL raster-scan coordinates: h increments per handshake; at h=WIDTH-1 it wraps to 0 and v increments; both reset to 0 on entering DISPATCH.
REQ-012 SHALL keep an outstanding counter of width clog2(WIDTH*HEIGHT+1): +1 on request handshake, -1 on output handshake, unchanged when both occur in one cycle.
REQ-013 SHALL hold one output register; it loads when empty or when out_valid&&out_ready in the same cycle, giving zero-bubble streaming.
REQ-014 SHALL select the loaded result round-robin among asserted lane_res_valid using a separate result pointer, and pulse lane_res_ready only on the selected lane in that cycle.
REQ-015 SHALL hold out_pixel, out_h and out_v stable while out_valid=1 and out_ready=0.
REQ-016 SHALL convert each component to unsigned code of k bits (r5 g6 b5 for PIXEL_FMT=0; 8/8/8 for 1) as component bits [FP_FRAC-1 : FP_FRAC-k].
REQ-017 SHALL pack PIXEL_FMT=0 as {8'b0, b[4:0], g[5:0], r[4:0]} and PIXEL_FMT=1 as {b, g, r}.
REQ-018 SHALL have conversion latency of 0 beyond the output register: a result accepted in cycle n is on out_pixel in cycle n+1.
REQ-019 SHALL pulse frame_done for exactly one cycle on the DRAIN->IDLE transition; start arriving in that same cycle SHALL be ignored.
REQ-020 SHALL accept results arriving in any order and pass them to the output with their own h/v (no reordering).

Reset
REQ-021 SHALL, on rst_n=0 and independent of clk, go to IDLE and set busy, frame_done, out_valid, lane_req_valid, lane_res_ready to 0, set out_pixel, out_h, out_v, both pointers, coordinates and outstanding count to 0.
REQ-022 SHALL abandon any in-flight frame on reset mid-operation; results presented after release while IDLE SHALL still be drained to the output without changing the count below 0.

Configuration
REQ-023 SHALL support macro RTX_DISPATCH_CLIP_EN: when defined, a negative component converts to 0 and a component >=1.0 converts to all-ones; when undefined, the REQ-016 bit-select alone applies, so out-of-range values wrap.

Verification
REQ-024 SHALL pass the following: WIDTH=4, HEIGHT=2, NUM_LANES=2, lanes always ready, 3-cycle fixed-latency results -> 8 requests (0,0)..(3,1) in raster order on alternating lanes, 8 outputs, one frame_done pulse, busy then 0.
REQ-025 SHALL pass the following: out_ready held 0 for 10 cycles mid-frame -> out_pixel/out_h/out_v stable, no lane_res_ready pulses, no result lost after release.
REQ-026 SHALL pass the following: both lanes present results in the same cycle, twice -> the grant alternates lane 0 then lane 1.
REQ-027 SHALL pass the following: PIXEL_FMT=0, FP_FRAC=16, r=g=b=0x008000 (0.5) -> out_pixel=0x008410; r=0x018000 -> out_pixel=0x00841F with RTX_DISPATCH_CLIP_EN, and 0x008410 without it.
REQ-028 SHALL pass the following: rst_n driven low at an arbitrary cycle mid-DISPATCH -> all REQ-021 values are seen immediately; a later start renders a full frame from (0,0).
